// File: rtl/shim_argmax.sv
// shim_argmax: classifier decision stage. Captures a vector of signed elements
// and scans one element per clock. It reports the index and value of the largest element.
module shim_argmax #(
   parameter int NUM_INPUTS = 10,
   parameter int WIDTH      = 8,
   localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                        CLK,
   input  logic                        RSTN,
   input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
   input  logic                        VALID_IN,
   output logic [IDX_W-1:0]            MAX_INDEX,
   output logic [WIDTH-1:0]            MAX_VALUE,
   output logic                        VALID_OUT,
   output logic                        BUSY,
   output logic                        OVERRUN
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic signed [WIDTH-1:0] vec_r [NUM_INPUTS];
   logic [IDX_W-1:0]        ptr_r;
   logic signed [WIDTH-1:0] cur_max_r;
   logic [IDX_W-1:0]        cur_idx_r;
   logic [IDX_W-1:0]        max_index_r;
   logic [WIDTH-1:0]        max_value_r;
   logic                    valid_out_r;
   logic                    busy_r;
   logic                    overrun_r;
   logic signed [WIDTH-1:0] elem_s;

   assign elem_s    = vec_r[ptr_r];
   assign MAX_INDEX = max_index_r;
   assign MAX_VALUE = max_value_r;
   assign VALID_OUT = valid_out_r;
   assign BUSY      = busy_r;
   assign OVERRUN   = overrun_r;

   // Capture / scan / report FSM with all outputs registered.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r     <= ST_IDLE;
         ptr_r       <= '0;
         cur_max_r   <= '0;
         cur_idx_r   <= '0;
         max_index_r <= '0;
         max_value_r <= '0;
         valid_out_r <= 1'b0;
         busy_r      <= 1'b0;
         overrun_r   <= 1'b0;
         for (int i = 0; i < NUM_INPUTS; i++) begin
            vec_r[i] <= '0;
         end
      end else begin
         valid_out_r <= 1'b0;
         // A pulse arriving while busy is dropped; the scan carries on untouched.
         if (VALID_IN && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
         case (state_r)
            ST_IDLE: begin
               if (VALID_IN) begin
                  for (int i = 0; i < NUM_INPUTS; i++) begin
                     vec_r[i] <= VALUES_IN[i*WIDTH +: WIDTH];
                  end
                  cur_max_r <= VALUES_IN[WIDTH-1:0];
                  cur_idx_r <= '0;
                  ptr_r     <= ONE_IDX;
                  busy_r    <= 1'b1;
                  state_r   <= (NUM_INPUTS > 1) ? ST_SCAN : ST_DONE;
               end else begin
                  busy_r    <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               // Strict compare keeps the lowest index on ties.
               if (elem_s > cur_max_r) begin
                  cur_max_r <= elem_s;
                  cur_idx_r <= ptr_r;
               end else begin
                  cur_max_r <= cur_max_r;
               end
               if (ptr_r == LAST_IDX) begin
                  state_r <= ST_DONE;
               end else begin
                  ptr_r   <= ptr_r + ONE_IDX;
               end
            end
            ST_DONE: begin
               max_value_r <= cur_max_r;
               max_index_r <= cur_idx_r;
               valid_out_r <= 1'b1;
               busy_r      <= 1'b0;
               state_r     <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shim_argmax.sv
// Scoreboard bench for shim_argmax: a 4-element build and a 1-element build
// share clock and reset; monitors pop expected results on every VALID_OUT.
module tb_shim_argmax;

   typedef struct {
      int idx;
      int val;
      int cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] values4 = '0;
   logic        valid4 = 1'b0;
   logic [1:0]  idx4;
   logic [7:0]  val4;
   logic        vo4, busy4, ovr4;
   logic [7:0]  values1 = '0;
   logic        valid1 = 1'b0;
   logic [0:0]  idx1;
   logic [7:0]  val1;
   logic        vo1, busy1, ovr1;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   exp_t q4[$];
   exp_t q1[$];

   shim_argmax #(.NUM_INPUTS(4), .WIDTH(8)) dut4 (
      .CLK(clk), .RSTN(rstn), .VALUES_IN(values4), .VALID_IN(valid4),
      .MAX_INDEX(idx4), .MAX_VALUE(val4), .VALID_OUT(vo4), .BUSY(busy4), .OVERRUN(ovr4)
   );

   shim_argmax #(.NUM_INPUTS(1), .WIDTH(8)) dut1 (
      .CLK(clk), .RSTN(rstn), .VALUES_IN(values1), .VALID_IN(valid1),
      .MAX_INDEX(idx1), .MAX_VALUE(val1), .VALID_OUT(vo1), .BUSY(busy1), .OVERRUN(ovr1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input int e0, input int e1, input int e2, input int e3);
      logic [31:0] a, b, c, d;
      a = e0; b = e1; c = e2; d = e3;
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   // Called at a negedge; pulse is sampled at the next posedge (edge k).
   task automatic send4(input logic [31:0] v, input int eidx, input int evalue);
      exp_t e;
      logic [31:0] t;
      values4 = v;
      valid4  = 1'b1;
      @(negedge clk);
      valid4  = 1'b0;
      t       = evalue;
      e.idx   = eidx;
      e.val   = int'(t[7:0]);
      e.cyc   = cyc + 4;
      q4.push_back(e);
   endtask

   task automatic send1(input logic [7:0] v, input int evalue);
      exp_t e;
      logic [31:0] t;
      values1 = v;
      valid1  = 1'b1;
      @(negedge clk);
      valid1  = 1'b0;
      t       = evalue;
      e.idx   = 0;
      e.val   = int'(t[7:0]);
      e.cyc   = cyc + 1;
      q1.push_back(e);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 40 && (q4.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      check("drain_timeout", q4.size() + q1.size(), 0);
   endtask

   // Monitor for the 4-element build.
   always @(negedge clk) begin
      if (vo4) begin
         if (q4.size() == 0) begin
            check("unexpected_valid_out4", 1, 0);
         end else begin
            exp_t e;
            e = q4.pop_front();
            check("max_index4", int'(idx4), e.idx);
            check("max_value4", int'(val4), e.val);
            check("latency4", cyc, e.cyc);
         end
      end
   end

   // Monitor for the 1-element build.
   always @(negedge clk) begin
      if (vo1) begin
         if (q1.size() == 0) begin
            check("unexpected_valid_out1", 1, 0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("max_index1", int'(idx1), e.idx);
            check("max_value1", int'(val1), e.val);
            check("latency1", cyc, e.cyc);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_index4", int'(idx4), 0);
      check("rst_value4", int'(val4), 0);
      check("rst_vo4", int'(vo4), 0);
      check("rst_busy4", int'(busy4), 0);
      check("rst_ovr4", int'(ovr4), 0);
      check("rst_vo1", int'(vo1), 0);
      check("rst_busy1", int'(busy1), 0);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Ties on 7: index 2 wins; BUSY high for exactly 4 cycles.
      send4(pack4(3, -5, 7, 7), 2, 7);
      check("busy_k0", int'(busy4), 1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         check("busy_scan", int'(busy4), 1);
      end
      @(negedge clk);
      check("busy_end", int'(busy4), 0);
      wait_drain();
      repeat (3) @(negedge clk);
      check("hold_value", int'(val4), 7);
      check("hold_index", int'(idx4), 2);

      send4(pack4(-8, -3, -100, -3), 1, -3);
      wait_drain();

      // Uniform minimum, then a new vector issued in the VALID_OUT cycle.
      send4(pack4(-128, -128, -128, -128), 0, -128);
      repeat (4) @(negedge clk);
      check("vo_cycle", int'(vo4), 1);
      send4(pack4(0, 0, 0, 1), 3, 1);
      wait_drain();
      check("no_overrun", int'(ovr4), 0);

      // Second pulse two cycles later is dropped and flagged.
      send4(pack4(1, 2, 3, 4), 3, 4);
      @(negedge clk);
      values4 = pack4(100, 100, 100, 100);
      valid4  = 1'b1;
      @(negedge clk);
      valid4  = 1'b0;
      wait_drain();
      repeat (8) @(negedge clk);
      check("overrun_set", int'(ovr4), 1);

      // Asynchronous reset two cycles into a scan.
      send4(pack4(5, 6, 7, 8), 3, 8);
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      check("arst_index", int'(idx4), 0);
      check("arst_value", int'(val4), 0);
      check("arst_vo", int'(vo4), 0);
      check("arst_busy", int'(busy4), 0);
      check("arst_ovr", int'(ovr4), 0);
      q4.delete();
      @(negedge clk);
      rstn = 1'b1;
      repeat (8) @(negedge clk);
      send4(pack4(1, 9, 2, 9), 1, 9);
      wait_drain();

      send1(8'hF9, -7);
      wait_drain();
      check("busy1_end", int'(busy1), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
